controller_command_fifo_bank: RTL and testbench
===============================================

Name: controller_command_fifo_bank

Overview:
- Per-channel command buffer directly downstream of the DRAM-initialisation and IO-scheduling command generators.
- Accepts a 128-bit controller command plus an 8-bit channel write-enable vector (one bit per flash channel). Queues the command into each enabled channel's FIFO.
- Presents each queue first-word-fall-through to its flash channel controller.
- Generates all_Cmd_Available_flag, the backpressure the generators poll before issuing a command.

Parameters:
- COMMAND_WIDTH, 128, width of one controller command (4 x 32-bit words).
- CHANNEL_NUM, 8, number of flash channels / FIFOs.
- FIFO_DEPTH, 4, entries per channel FIFO (power of two, >= 4).
- FIFO_ADDR_WIDTH, 2, log2(FIFO_DEPTH).

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- controller_command_fifo_in  in  COMMAND_WIDTH  command word, shared by all channels.
- controller_command_fifo_in_en  in  CHANNEL_NUM  per-channel write enable; multiple bits may be set (broadcast).
- all_Cmd_Available_flag  out  1  registered; high = every channel can accept one more command.
- cmd_out_data  out  CHANNEL_NUM*COMMAND_WIDTH  head entry per channel; channel i occupies bits [i*COMMAND_WIDTH +: COMMAND_WIDTH].
- cmd_out_valid  out  CHANNEL_NUM  channel i FIFO non-empty.
- cmd_out_rd_en  in  CHANNEL_NUM  channel controller pops head entry.
- fifo_all_empty  out  1  registered; all FIFOs empty and no write pending.
- overflow_err  out  1  sticky; a write hit a full FIFO.
- underflow_err  out  1  sticky; a pop hit an empty FIFO.

Behaviour:
- Reset (sync, high, on the clk edge):
  - All pointers and counts go to 0.
  - cmd_out_valid=0, all_Cmd_Available_flag=0, fifo_all_empty=1, overflow_err=0, underflow_err=0.
  - cmd_out_data is don't-care while valid=0.
  - all_Cmd_Available_flag rises on the first clock after reset is released.
- Write: on each edge, for each channel i with in_en[i]=1 and (count_i<FIFO_DEPTH or rd_en[i]=1 with count_i>0):
  - store the command at wr_ptr_i;
  - wr_ptr_i wraps modulo FIFO_DEPTH.
- Read: FWFT.
  - cmd_out_valid[i] = (count_i!=0).
  - Data is the head entry, combinational from storage.
  - rd_en[i]=1 with count_i>0 advances rd_ptr_i (wraps).
- Simultaneous read and write on a channel:
  - legal at any count, including full and empty;
  - count is unchanged when count>0;
  - when empty, the write lands and the read is an underflow (not serviced).
- count_next_i = count_i + write_accepted_i - read_accepted_i. Width is FIFO_ADDR_WIDTH+1; never wraps.
- all_Cmd_Available_flag <= AND over i of (count_next_i <= FIFO_DEPTH-2).
  - The threshold leaves one spare slot. A producer that samples the flag high and drives in_en on the following cycle (one cycle of flight) can never overflow, even when it writes on two consecutive cycles.
- Overflow:
  - write to channel i when count_i==FIFO_DEPTH and rd_en[i]=0 is dropped;
  - overflow_err <= 1 until reset;
  - other enabled channels in the same cycle still write.
- Underflow:
  - rd_en[i] with count_i==0 is ignored;
  - underflow_err <= 1 (sticky).
- fifo_all_empty <= AND over i of (count_next_i==0).
- No internal state machine beyond per-channel pointer/count. Latency from write edge to cmd_out_valid high is 1 cycle.
- Reset asserted mid-traffic: all queued commands are discarded on that edge; in-flight en ignored.

Decomposition:
- Shared package/define file (ftl_define.v): COMMAND_WIDTH and channel count, alongside the existing command field constants.
- One sub-module, cmd_channel_fifo:
  - single FWFT FIFO with wr_en, din, rd_en, dout, count, full, empty, and per-instance overflow/underflow pulses;
  - instantiated CHANNEL_NUM times via generate.
- Top level holds the flag/empty reductions and sticky error registers.

Test Plan:
- Reset release -> cycle 0: valid=8'h00, fifo_all_empty=1, flag=0. Next cycle: flag=1.
- Write cmd 128'h0001_... with en=8'h01, no reads:
  - cycle+1: valid=8'h01, cmd_out_data[127:0] = the command;
  - after 3 writes: flag=0 (count 3 > DEPTH-2=2);
  - 4th write accepted, overflow_err=0.
- Producer model writes whenever it sampled flag=1 the previous cycle, en=8'h04, no reads, 20 cycles -> channel 2 count peaks at 4, overflow_err stays 0.
- Broadcast en=8'hFF of 0xA5..A5 -> all 8 valid bits set next cycle, every slice equals the word. Pop channel 7 only -> valid=8'h7F, flag unchanged until counts drop.
- Channel 3 full (4 entries), assert en[3] and rd_en[3] in the same cycle:
  - count stays 4, oldest entry is removed, new entry appears 4th in order;
  - then en[3] alone: dropped, overflow_err=1.
- rd_en=8'h10 on an empty FIFO -> underflow_err=1, valid unchanged. Reset mid-stream with 2 entries queued -> next cycle valid=0, both error flags cleared.

Source files
------------

// File: rtl/controller_command_fifo_bank_pkg.sv
// Shared sizing for the controller command FIFO bank.
// Command width, channel count and per-channel FIFO geometry.
package controller_command_fifo_bank_pkg;

  localparam int COMMAND_WIDTH   = 128;
  localparam int CHANNEL_NUM     = 8;
  localparam int FIFO_DEPTH      = 4;
  localparam int FIFO_ADDR_WIDTH = 2;
  localparam int CNT_W           = FIFO_ADDR_WIDTH + 1;

  typedef logic [COMMAND_WIDTH-1:0] cmd_t;
  typedef logic [CNT_W-1:0]         cnt_t;

  localparam cnt_t DEPTH_C = cnt_t'(FIFO_DEPTH);
  localparam cnt_t AVAIL_C = cnt_t'(FIFO_DEPTH - 2);

endpackage

// File: rtl/controller_command_fifo_bank_fifo.sv
// Single first-word-fall-through command FIFO for one channel.
// A pop frees the head slot, so a write into a full FIFO is accepted.
module cmd_channel_fifo
  import controller_command_fifo_bank_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic wr_en,
  input  cmd_t din,
  input  logic rd_en,
  output cmd_t dout,
  output cnt_t count,
  output cnt_t count_nxt,
  output logic full,
  output logic empty,
  output logic ovf,
  output logic udf
);

  typedef logic [FIFO_ADDR_WIDTH-1:0] ptr_t;

  cmd_t mem_q [FIFO_DEPTH];
  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  cnt_t count_q, count_d;
  logic wr_acc, rd_acc;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);
  assign ovf    = wr_en && full && !rd_en;
  assign udf    = rd_en && empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_acc && !rd_acc) count_d = count_q + 1'b1;
    if (!wr_acc && rd_acc) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; its contents are ignored while empty.
  always_ff @(posedge clk) begin
    if (!reset && wr_acc) mem_q[wr_ptr_q] <= din;
  end

  assign dout      = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign count_nxt = count_d;

endmodule

// File: rtl/controller_command_fifo_bank.sv
// Per-channel command buffer bank with broadcast write and
// registered availability / empty flags plus sticky errors.
module controller_command_fifo_bank
  import controller_command_fifo_bank_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [COMMAND_WIDTH-1:0]             controller_command_fifo_in,
  input  logic [CHANNEL_NUM-1:0]               controller_command_fifo_in_en,
  output logic                                 all_Cmd_Available_flag,
  output logic [CHANNEL_NUM*COMMAND_WIDTH-1:0] cmd_out_data,
  output logic [CHANNEL_NUM-1:0]               cmd_out_valid,
  input  logic [CHANNEL_NUM-1:0]               cmd_out_rd_en,
  output logic                                 fifo_all_empty,
  output logic                                 overflow_err,
  output logic                                 underflow_err
);

  cnt_t cnt_v     [CHANNEL_NUM];
  cnt_t cnt_nxt_v [CHANNEL_NUM];
  logic [CHANNEL_NUM-1:0] full_v, empty_v;
  logic [CHANNEL_NUM-1:0] ovf_v, udf_v;
  logic [CHANNEL_NUM-1:0] avail_v, idle_v;

  logic flag_q, flag_d;
  logic mt_q, mt_d;
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  for (genvar i = 0; i < CHANNEL_NUM; i++) begin : g_ch
    cmd_channel_fifo u_fifo (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (controller_command_fifo_in_en[i]),
      .din       (controller_command_fifo_in),
      .rd_en     (cmd_out_rd_en[i]),
      .dout      (cmd_out_data[i*COMMAND_WIDTH +: COMMAND_WIDTH]),
      .count     (cnt_v[i]),
      .count_nxt (cnt_nxt_v[i]),
      .full      (full_v[i]),
      .empty     (empty_v[i]),
      .ovf       (ovf_v[i]),
      .udf       (udf_v[i])
    );

    // One spare slot covers a producer with one cycle of flag latency.
    assign avail_v[i] = (cnt_nxt_v[i] <= AVAIL_C);
    assign idle_v[i]  = (cnt_nxt_v[i] == '0);

    a_full: assert property (@(posedge clk) disable iff (reset)
      full_v[i] == (cnt_v[i] == DEPTH_C));
  end

  assign cmd_out_valid = ~empty_v;

  always_comb begin
    flag_d = &avail_v;
    mt_d   = &idle_v;
    ovf_d  = ovf_q | (|ovf_v);
    udf_d  = udf_q | (|udf_v);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flag_q <= 1'b0;
      mt_q   <= 1'b1;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      flag_q <= flag_d;
      mt_q   <= mt_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

  assign all_Cmd_Available_flag = flag_q;
  assign fifo_all_empty         = mt_q;
  assign overflow_err           = ovf_q;
  assign underflow_err          = udf_q;

endmodule

// File: tb/tb_controller_command_fifo_bank.sv
// Scoreboard bench for the command FIFO bank.
// Per-channel queues model contents; heads are checked each cycle.
module tb_controller_command_fifo_bank;
  import controller_command_fifo_bank_pkg::*;

  logic clk = 1'b0;
  logic reset;
  cmd_t din;
  logic [CHANNEL_NUM-1:0] en, rd;
  logic flag, mt, ovf, udf;
  logic [CHANNEL_NUM-1:0] valid;
  logic [CHANNEL_NUM*COMMAND_WIDTH-1:0] dout;

  always #5 clk = ~clk;

  controller_command_fifo_bank dut (
    .clk                           (clk),
    .reset                         (reset),
    .controller_command_fifo_in    (din),
    .controller_command_fifo_in_en (en),
    .all_Cmd_Available_flag        (flag),
    .cmd_out_data                  (dout),
    .cmd_out_valid                 (valid),
    .cmd_out_rd_en                 (rd),
    .fifo_all_empty                (mt),
    .overflow_err                  (ovf),
    .underflow_err                 (udf)
  );

  cmd_t q [CHANNEL_NUM][$];
  logic e_flag, e_mt, e_ovf, e_udf;
  int n_chk = 0;
  int n_pass = 0;
  int peak2 = 0;

  task automatic chk(input string tag, input cmd_t got, input cmd_t exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic check_state();
    logic [CHANNEL_NUM-1:0] ev;
    for (int i = 0; i < CHANNEL_NUM; i++) ev[i] = (q[i].size() != 0);
    chk("valid", cmd_t'(valid), cmd_t'(ev));
    chk("flag", cmd_t'(flag), cmd_t'(e_flag));
    chk("empty", cmd_t'(mt), cmd_t'(e_mt));
    chk("ovf", cmd_t'(ovf), cmd_t'(e_ovf));
    chk("udf", cmd_t'(udf), cmd_t'(e_udf));
    for (int i = 0; i < CHANNEL_NUM; i++)
      if (q[i].size() != 0)
        chk($sformatf("head%0d", i),
            dout[i*COMMAND_WIDTH +: COMMAND_WIDTH], q[i][0]);
  endtask

  task automatic step(input logic [CHANNEL_NUM-1:0] w,
                      input logic [CHANNEL_NUM-1:0] r,
                      input cmd_t d, input logic rst = 1'b0);
    @(negedge clk);
    check_state();
    en = w; rd = r; din = d; reset = rst;
    if (rst) begin
      for (int i = 0; i < CHANNEL_NUM; i++) q[i].delete();
      e_flag = 1'b0; e_mt = 1'b1; e_ovf = 1'b0; e_udf = 1'b0;
    end else begin
      e_flag = 1'b1; e_mt = 1'b1;
      for (int i = 0; i < CHANNEL_NUM; i++) begin
        int sz;
        logic ra, wa;
        sz = q[i].size();
        ra = r[i] && sz > 0;
        wa = w[i] && (sz < FIFO_DEPTH || ra);
        if (w[i] && sz == FIFO_DEPTH && !r[i]) e_ovf = 1'b1;
        if (r[i] && sz == 0) e_udf = 1'b1;
        if (ra) void'(q[i].pop_front());
        if (wa) q[i].push_back(d);
        if (q[i].size() > FIFO_DEPTH - 2) e_flag = 1'b0;
        if (q[i].size() != 0) e_mt = 1'b0;
      end
      if (q[2].size() > peak2) peak2 = q[2].size();
    end
    @(posedge clk);
  endtask

  function automatic cmd_t mk(input int n);
    return {32'(n), 32'hC0DE_0000 | 32'(n), 32'(~n), 32'(n * 7)};
  endfunction

  initial begin
    cmd_t a5;
    logic pf;
    a5 = {16{8'hA5}};
    en = '0; rd = '0; din = '0; reset = 1'b1;
    e_flag = 1'b0; e_mt = 1'b1; e_ovf = 1'b0; e_udf = 1'b0;
    step('0, '0, '0, 1'b1);
    step('0, '0, '0, 1'b1);
    // first cycle after release: flag still low
    @(negedge clk);
    reset = 1'b0;
    check_state();
    @(posedge clk);
    e_flag = 1'b1;
    step('0, '0, '0);

    for (int k = 0; k < 4; k++) step(8'h01, '0, mk(k + 1));
    step('0, '0, '0);
    chk("ch0_first", dout[COMMAND_WIDTH-1:0], mk(1));
    for (int k = 0; k < 4; k++) step('0, 8'h01, '0);

    step('0, '0, '0, 1'b1);
    step('0, '0, '0);
    pf = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step(pf ? 8'h04 : 8'h00, '0, mk(100 + k));
      pf = flag;
    end
    chk("peak2", cmd_t'(peak2), cmd_t'(FIFO_DEPTH));
    chk("prod_ovf", cmd_t'(ovf), '0);

    step('0, '0, '0, 1'b1);
    step('0, '0, '0);
    step(8'hFF, '0, a5);
    step('0, 8'h80, '0);
    step('0, '0, '0);
    chk("pop7_valid", cmd_t'(valid), cmd_t'(8'h7F));
    step('0, 8'h7F, '0);

    for (int k = 0; k < 4; k++) step(8'h08, '0, mk(200 + k));
    step(8'h08, 8'h08, mk(300));
    step(8'h08, '0, mk(301));
    for (int k = 0; k < 5; k++) step('0, 8'h08, '0);

    step('0, 8'h10, '0);
    step(8'h21, '0, mk(400));
    step(8'h21, 8'h20, mk(401));
    step(8'h01, '0, mk(402), 1'b1);
    step('0, '0, '0);
    step('0, '0, '0);
    @(negedge clk);
    check_state();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
